// File: rtl/cache_ctrl_pkg.sv
// Shared types and geometry for the 4-way, 4-set write-back data cache controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB_REQ = 3'd1,
    RF_REQ = 3'd2,
    UPDATE = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam int unsigned NUM_SETS    = 4;
  localparam int unsigned WAYS        = 4;
  localparam int unsigned BLOCK_WORDS = 4;

endpackage

// File: rtl/cache_miss_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the performance counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss sequencing controller: write-back eviction, refill, CPU stall and memory timeout.
// Optional performance counters are built when CACHE_CTRL_PERF_EN is defined.
module cache_miss_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic             hit,
  input  logic             miss,
  input  logic             victim_valid,
  input  logic             victim_dirty,
  input  logic             mem_ack,
  output logic             writeback,
  output logic             update,
  output logic             mem_wr_req,
  output logic             mem_rd_req,
  output logic             stall,
  output logic             err,
  output logic [2:0]       state_o
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
`endif
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic [TW-1:0] tcnt;
  logic          req, in_xfer, tmo;

  assign req     = cpu_read | cpu_write;
  assign in_xfer = (state == WB_REQ) || (state == RF_REQ);
  // Expiry is detected one count early so ERROR lands after exactly TIMEOUT_CYCLES waiting cycles.
  assign tmo     = (TIMEOUT_CYCLES != 0) && (tcnt == TLAST);
  assign stall   = (state != IDLE) | (req & miss);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req && miss) state_n = (victim_valid && victim_dirty) ? WB_REQ : RF_REQ;
      WB_REQ:  if (mem_ack) state_n = RF_REQ; else if (tmo) state_n = ERROR;
      RF_REQ:  if (mem_ack) state_n = UPDATE; else if (tmo) state_n = ERROR;
      UPDATE:  state_n = IDLE;
      ERROR:   state_n = ERROR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      tcnt       <= '0;
      writeback  <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_rd_req <= 1'b0;
      update     <= 1'b0;
      err        <= 1'b0;
      state_o    <= '0;
    end else begin
      state      <= state_n;
      writeback  <= (state_n == WB_REQ);
      mem_wr_req <= (state_n == WB_REQ);
      mem_rd_req <= (state_n == RF_REQ);
      update     <= (state_n == UPDATE);
      err        <= (state_n == ERROR);
      state_o    <= state_n;
      if ((state_n != state) && ((state_n == WB_REQ) || (state_n == RF_REQ))) begin
        tcnt <= '0;
      end else if (in_xfer && !mem_ack && (tcnt != '1)) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic replay;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) replay <= 1'b0;
    else     replay <= (state == UPDATE);
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc ((state == IDLE) & req & hit & ~miss & ~replay),
    .clr (1'b0),
    .q   (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc ((state == IDLE) & req & miss),
    .clr (1'b0),
    .q   (miss_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wb_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc ((state == WB_REQ) & mem_ack),
    .clr (1'b0),
    .q   (wb_cnt)
  );
`else
  logic unused_hit;
  assign unused_hit = &{1'b0, hit};
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed self-checking bench for cache_miss_ctrl (counter checks when CACHE_CTRL_PERF_EN is defined).
module tb_cache_miss_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0, hit = 1'b0, miss = 1'b0;
  logic        victim_valid = 1'b0, victim_dirty = 1'b0, mem_ack = 1'b0;
  logic        writeback, update, mem_wr_req, mem_rd_req, stall, err;
  logic [2:0]  state_o;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  cache_miss_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .hit          (hit),
    .miss         (miss),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .mem_ack      (mem_ack),
    .writeback    (writeback),
    .update       (update),
    .mem_wr_req   (mem_wr_req),
    .mem_rd_req   (mem_rd_req),
    .stall        (stall),
    .err          (err),
    .state_o      (state_o)
`ifdef CACHE_CTRL_PERF_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .wb_cnt       (wb_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change mid-cycle (negedge); outputs are sampled 1 time unit later.
  task automatic drive(input logic rd, input logic wr, input logic h, input logic m,
                       input logic vv, input logic vd, input logic ack);
    @(negedge CLK);
    cpu_read = rd; cpu_write = wr; hit = h; miss = m;
    victim_valid = vv; victim_dirty = vd; mem_ack = ack;
    #1;
  endtask

  // Expected fields: writeback, update, mem_wr_req, mem_rd_req, stall, err, state.
  task automatic expect_o(input string tag, input logic wb, input logic up, input logic wr,
                          input logic rd, input logic st, input logic er, input logic [2:0] s);
    check(tag, {23'b0, writeback, update, mem_wr_req, mem_rd_req, stall, err, state_o},
               {23'b0, wb, up, wr, rd, st, er, s});
  endtask

  task automatic reset_pulse();
    @(negedge CLK);
    RST = 1'b1;
    cpu_read = 0; cpu_write = 0; hit = 0; miss = 0;
    victim_valid = 0; victim_dirty = 0; mem_ack = 0;
    #1;
    expect_o("async_reset", 0, 0, 0, 0, 0, 0, 3'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    expect_o("reset_state", 0, 0, 0, 0, 0, 0, 3'd0);
`ifdef CACHE_CTRL_PERF_EN
    check("reset_hit_cnt", hit_cnt, 32'd0);
`endif
    @(negedge CLK);
    RST = 1'b0;

    // Read hit: no stall, stays in IDLE
    drive(1, 0, 1, 0, 0, 0, 0); expect_o("hit_c0", 0, 0, 0, 0, 0, 0, 3'd0);
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("hit_c1", 0, 0, 0, 0, 0, 0, 3'd0);
`ifdef CACHE_CTRL_PERF_EN
    check("hit_cnt_1", hit_cnt, 32'd1);
`endif

    // Clean read miss, ack 3 cycles after mem_rd_req rises
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("clean_c0", 0, 0, 0, 0, 1, 0, 3'd0);
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("clean_c1", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("clean_c2", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("clean_c3", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(1, 0, 0, 1, 0, 0, 1); expect_o("clean_c4", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("clean_c5", 0, 1, 0, 0, 1, 0, 3'd3);
    drive(1, 0, 1, 0, 0, 0, 0); expect_o("clean_c6", 0, 0, 0, 0, 0, 0, 3'd0);
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("clean_c7", 0, 0, 0, 0, 0, 0, 3'd0);
`ifdef CACHE_CTRL_PERF_EN
    check("clean_miss_cnt", miss_cnt, 32'd1);
    check("clean_replay_hit_cnt", hit_cnt, 32'd1);
`endif

    // Dirty store miss, ack latency 2 on both transfers
    drive(0, 1, 0, 1, 1, 1, 0); expect_o("dirty_c0", 0, 0, 0, 0, 1, 0, 3'd0);
    drive(0, 1, 0, 1, 1, 1, 0); expect_o("dirty_c1", 1, 0, 1, 0, 1, 0, 3'd1);
    drive(0, 1, 0, 1, 1, 1, 0); expect_o("dirty_c2", 1, 0, 1, 0, 1, 0, 3'd1);
    drive(0, 1, 0, 1, 1, 1, 1); expect_o("dirty_c3", 1, 0, 1, 0, 1, 0, 3'd1);
    drive(0, 1, 0, 1, 1, 1, 0); expect_o("dirty_c4", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(0, 1, 0, 1, 1, 1, 0); expect_o("dirty_c5", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(0, 1, 0, 1, 1, 1, 1); expect_o("dirty_c6", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(0, 1, 0, 1, 1, 1, 0); expect_o("dirty_c7", 0, 1, 0, 0, 1, 0, 3'd3);
    drive(0, 1, 1, 0, 1, 1, 0); expect_o("dirty_c8", 0, 0, 0, 0, 0, 0, 3'd0);
    drive(1, 0, 1, 0, 0, 0, 0); expect_o("dirty_c9", 0, 0, 0, 0, 0, 0, 3'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef CACHE_CTRL_PERF_EN
    check("dirty_wb_cnt", wb_cnt, 32'd1);
    check("dirty_miss_cnt", miss_cnt, 32'd2);
    check("dirty_hit_cnt", hit_cnt, 32'd2);
`endif

    // Ack on the cycle the timeout would expire: ack wins
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("ackwin_c0", 0, 0, 0, 0, 1, 0, 3'd0);
    for (int i = 1; i <= 7; i++) begin
      drive(1, 0, 0, 1, 0, 0, 0); expect_o($sformatf("ackwin_c%0d", i), 0, 0, 0, 1, 1, 0, 3'd2);
    end
    drive(1, 0, 0, 1, 0, 0, 1); expect_o("ackwin_c8", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("ackwin_c9", 0, 1, 0, 0, 1, 0, 3'd3);
    drive(1, 0, 1, 0, 0, 0, 0); expect_o("ackwin_c10", 0, 0, 0, 0, 0, 0, 3'd0);

    // Timeout: no ack, ERROR after 8 cycles in RF_REQ, sticky until RST
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("tmo_c0", 0, 0, 0, 0, 1, 0, 3'd0);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 0, 1, 0, 0, 0); expect_o($sformatf("tmo_c%0d", i), 0, 0, 0, 1, 1, 0, 3'd2);
    end
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("tmo_err", 0, 0, 0, 0, 1, 1, 3'd4);
    drive(0, 0, 0, 0, 0, 0, 1); expect_o("tmo_err_ack", 0, 0, 0, 0, 1, 1, 3'd4);
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("tmo_err_hold", 0, 0, 0, 0, 1, 1, 3'd4);
    reset_pulse();
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("tmo_after_rst", 0, 0, 0, 0, 0, 0, 3'd0);
`ifdef CACHE_CTRL_PERF_EN
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif

    // RST during WB_REQ: clears immediately, no update, fresh sequence afterwards
    drive(0, 1, 0, 1, 1, 1, 0); expect_o("rstwb_c0", 0, 0, 0, 0, 1, 0, 3'd0);
    drive(0, 1, 0, 1, 1, 1, 0); expect_o("rstwb_c1", 1, 0, 1, 0, 1, 0, 3'd1);
    reset_pulse();
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("rstwb_no_update", 0, 0, 0, 0, 0, 0, 3'd0);
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("fresh_c0", 0, 0, 0, 0, 1, 0, 3'd0);
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("fresh_c1", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(1, 0, 0, 1, 0, 0, 1); expect_o("fresh_c2", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(1, 0, 0, 1, 0, 0, 0); expect_o("fresh_c3", 0, 1, 0, 0, 1, 0, 3'd3);
    drive(1, 0, 1, 0, 0, 0, 0); expect_o("fresh_c4", 0, 0, 0, 0, 0, 0, 3'd0);

    // Spurious ack in IDLE, hit+miss treated as miss, request withdrawn in RF_REQ
    drive(0, 0, 0, 0, 0, 0, 1); expect_o("spur_c0", 0, 0, 0, 0, 0, 0, 3'd0);
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("spur_c1", 0, 0, 0, 0, 0, 0, 3'd0);
    drive(1, 0, 1, 1, 0, 0, 0); expect_o("wd_c0", 0, 0, 0, 0, 1, 0, 3'd0);
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("wd_c1", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(0, 0, 0, 0, 0, 0, 1); expect_o("wd_c2", 0, 0, 0, 1, 1, 0, 3'd2);
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("wd_c3", 0, 1, 0, 0, 1, 0, 3'd3);
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("wd_c4", 0, 0, 0, 0, 0, 0, 3'd0);
    drive(0, 0, 0, 0, 0, 0, 0); expect_o("wd_c5", 0, 0, 0, 0, 0, 0, 3'd0);
`ifdef CACHE_CTRL_PERF_EN
    check("final_miss_cnt", miss_cnt, 32'd2);
    check("final_hit_cnt", hit_cnt, 32'd0);
    check("final_wb_cnt", wb_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Sequencing controller for the 4-way, 4-set write-back data cache. It watches the cache's combinational `hit`/`miss` and victim status, drives the cache's `writeback` and `update` strobes, and runs a req/ack handshake with data memory for dirty-block eviction and block refill. It stalls the CPU pipeline from miss detection until the refilled line is installed, and reports a sticky error on memory timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles a memory request may wait for `mem_ack`; 0 disables the timeout.
- `CNT_W`, default 32: width of the performance counters.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `cpu_read`  in  1  CPU load request; held stable while `stall`=1.
- `cpu_write`  in  1  CPU store request; held stable while `stall`=1.
- `hit`  in  1  cache combinational hit.
- `miss`  in  1  cache combinational miss.
- `victim_valid`  in  1  valid bit of the LRU way in the addressed set.
- `victim_dirty`  in  1  dirty bit of the LRU way in the addressed set.
- `mem_ack`  in  1  one-cycle memory completion pulse.
- `writeback`  out  1  cache drives victim block to memory.
- `update`  out  1  cache installs refill block; one-cycle pulse.
- `mem_wr_req`  out  1  memory block-write request.
- `mem_rd_req`  out  1  memory block-read request.
- `stall`  out  1  freeze the CPU pipeline.
- `err`  out  1  sticky memory-timeout error.
- `state_o`  out  3  current state encoding, for debug.
- `hit_cnt`, `miss_cnt`, `wb_cnt`  out  CNT_W each  performance counters. Present only with `CACHE_CTRL_PERF_EN`.

## Operation
- States and encodings: IDLE=0, WB_REQ=1, RF_REQ=2, UPDATE=3, ERROR=4.
- IDLE
  - With `(cpu_read|cpu_write)&miss`: go to WB_REQ if `victim_valid&victim_dirty`, otherwise to RF_REQ.
  - With a hit or no request: stay in IDLE.
- WB_REQ
  - `writeback`=1 and `mem_wr_req`=1, held until `mem_ack`.
  - On `mem_ack`, go to RF_REQ.
- RF_REQ
  - `mem_rd_req`=1, held until `mem_ack`.
  - On `mem_ack`, go to UPDATE.
- UPDATE
  - `update`=1 for exactly one cycle, then go to IDLE.
  - The request replays in IDLE and now hits.
  - A store replay rewrites the same word; this is harmless.
- ERROR
  - `stall`=1 and `err`=1.
  - Only `RST` exits ERROR.
- `stall` = (state≠IDLE) | (state==IDLE & request & miss).
  - This is combinational, so the miss cycle itself is stalled.
- Timeout counter
  - Clears on entry to WB_REQ or RF_REQ.
  - Increments each cycle without `mem_ack`.
  - Reaching `TIMEOUT_CYCLES` (nonzero) goes to ERROR.
  - The counter saturates and never wraps.
- `mem_ack` is ignored in IDLE, UPDATE and ERROR.
- `mem_ack` on the same cycle as timeout expiry counts as an ack: the ack wins.
- A request withdrawn mid-sequence does not abort it; the fill completes and the controller returns to IDLE.
- Both `hit` and `miss` asserted together is illegal: treat it as a miss.
- RST mid-sequence: next state is IDLE, all outputs go low, and no partial `update` is issued.

## Timing
- Reset values: state=IDLE, `writeback`=`update`=`mem_wr_req`=`mem_rd_req`=`err`=0, `state_o`=0, counters=0.
- `stall` is 0 at reset when no request is present.
- Hit latency: 0 extra cycles.
- Clean miss, with `mem_ack` A cycles after the request rises:
  - Cycle 0: miss detected.
  - Cycle 1: RF_REQ.
  - Cycle 1+A: ack.
  - Cycle 2+A: UPDATE.
  - Cycle 3+A: IDLE with hit, `stall`=0.
- Dirty miss adds 1+A_wb cycles for WB_REQ.
- Request outputs are registered, decoded from state; they are never combinational from inputs.

## Configuration
- `CACHE_CTRL_PERF_EN` defined:
  - `hit_cnt` increments on an IDLE request hit, except the replay cycle right after UPDATE.
  - `miss_cnt` increments on the IDLE→WB_REQ and IDLE→RF_REQ transitions.
  - `wb_cnt` increments on `mem_ack` in WB_REQ.
  - All counters saturate at 2^CNT_W−1.
- `CACHE_CTRL_PERF_EN` undefined: counter ports and logic are absent; FSM behaviour is identical.

## Structure
- `cache_ctrl_pkg` holds:
  - the state enum typedef, 3-bit, with the encodings above;
  - the shared geometry constants NUM_SETS=4, WAYS=4, BLOCK_WORDS=4.
- One sub-module, `sat_counter` (parameter W; inputs `inc` and `clr`; async reset), instantiated three times under the macro.

## Test plan
- Read hit: `cpu_read`=1, `hit`=1 → `stall`=0, state stays 0, `hit_cnt` 0→1.
- Clean read miss: `miss`=1, `victim_valid`=0, `mem_ack` 3 cycles after `mem_rd_req` → `mem_wr_req` never asserts, `update` pulses at cycle 5, `stall` drops at cycle 6, `miss_cnt`=1.
- Dirty store miss: `victim_valid`=`victim_dirty`=1, ack latency 2 on both transfers → `writeback`/`mem_wr_req` on cycles 1–3, `mem_rd_req` on cycles 4–6, `update` at cycle 7, `wb_cnt`=1.
- Timeout: `TIMEOUT_CYCLES`=8, no ack → ERROR after 8 cycles in RF_REQ, `err`=1 and `stall`=1 until RST; then all outputs are 0.
- RST asserted in WB_REQ → outputs clear asynchronously, no `update` pulse; the next request starts a fresh sequence from IDLE.
- Spurious `mem_ack` in IDLE plus a request withdrawn during RF_REQ → the ack is ignored, and the fill completes with one `update` before returning to IDLE.
